// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one STEP-bit ripple slice is reused every clock,
// with the carry registered between slices, so a WIDTH-bit result takes WIDTH/STEP cycles.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] shr_q, shr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [STEP:0]    carry;
  logic [STEP-1:0]  slice_sum;
  logic [WIDTH-1:0] slice_ext;
  logic [WIDTH-1:0] shr_shift;
  logic             last_step;

  // One full-adder cell per slice bit; carry[STEP-1] is the carry into the slice MSB.
  assign carry[0] = c_q;
  genvar gi;
  generate
    for (gi = 0; gi < STEP; gi++) begin : g_fa
      logic x_bit;
      logic y_bit;
      assign x_bit          = sha_q[gi];
      assign y_bit          = shb_q[gi];
      assign slice_sum[gi]  = x_bit ^ y_bit ^ carry[gi];
      assign carry[gi+1]    = (x_bit & y_bit) | (carry[gi] & (x_bit ^ y_bit));
    end
  endgenerate

  // New slice bits enter at the top of shR; after N steps the LSB slice sits at bit 0.
  assign slice_ext = WIDTH'(slice_sum);
  assign shr_shift = (shr_q >> STEP) | (slice_ext << (WIDTH - STEP));
  assign last_step = (cnt_q == CNT_W'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sha_q   <= '0;
      shb_q   <= '0;
      shr_q   <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      shr_q   <= shr_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    shr_d   = shr_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
          sha_d   = a;
          shb_d   = sub ? ~b : b;
          shr_d   = '0;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sha_d = sha_q >> STEP;
        shb_d = shb_q >> STEP;
        shr_d = shr_shift;
        c_d   = carry[STEP];
        cnt_d = cnt_q + CNT_W'(1);
        if (last_step) begin
          sum_d   = shr_shift;
          cout_d  = carry[STEP];
          ovf_d   = carry[STEP-1] ^ carry[STEP];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor. Successor to the single-bit gate-level full-adder cell.
- Reuses one STEP-bit ripple slice per clock, with a registered carry between steps, to add or subtract two WIDTH-bit operands over WIDTH/STEP cycles.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Intended for area-constrained datapaths where a full-width adder is too costly.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.
- STEP, 1, bits processed per clock; must divide WIDTH exactly (legal for 8: 1, 2, 4, 8).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled on rising clk.
- sub  input  1  mode, sampled with start: 0 = A+B, 1 = A-B (A + ~B + 1).
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- busy  output  1  high while computing.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow.
- ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0. Internal shift registers, carry and counter cleared. The operation in flight is abandoned; no done pulse follows.
- States: IDLE, RUN, DONE. N = WIDTH/STEP.
- IDLE or DONE with start=1 at edge E0:
  - Capture a into shA; capture b (or ~b if sub=1) into shB.
  - Carry register c = sub; counter = 0; state to RUN; busy=1 after E0.
- RUN, each edge:
  - Add the STEP LSBs of shA and shB with c as a STEP-bit ripple of full-adder cells.
  - Shift the STEP result bits into the top of result shift register shR.
  - Shift shA/shB right by STEP; c = slice carry out; counter++.
  - On the final (N-th) RUN edge, also record the carry into the MSB for overflow.
- After the N-th RUN edge (edge E0+N):
  - sum = shR; cout = c; ovf = c_into_msb XOR cout.
  - done=1, busy=0, state DONE.
- DONE lasts exactly one cycle:
  - done returns to 0 on the next edge (E0+N+1) and state goes to IDLE.
  - If start=1 on that edge, a new operation is accepted (back-to-back throughput N+1 cycles).
- Latency: start edge to done-high = N edges. For WIDTH=8, STEP=1: 8 cycles. For STEP=4: 2 cycles.
- start while RUN: ignored. Operands, mode and in-flight result unaffected.
- sum/cout/ovf hold their last values until the next completion. They do not change during RUN and are not cleared by start.
- Arithmetic is modulo 2^WIDTH. There are no internal width extensions visible at the ports.
- STEP=WIDTH is legal: a single RUN cycle, equivalent to a registered full-width adder.

Test Plan:
- WIDTH=8, STEP=1, add a=0x5A, b=0x3C -> done 8 cycles after start; sum=0x96, cout=0, ovf=1. busy high exactly 8 cycles.
- Add a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0.
- Sub a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then sub a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- start pulsed again at cycle 3 of RUN with different operands -> ignored; the original result is delivered on schedule. start held high through DONE -> a second operation begins; second done exactly 9 cycles after the first.
- Assert rst at cycle 4 of RUN -> busy=0, done=0, sum=0 immediately (asynchronous). No done pulse afterwards. A fresh start after reset release gives the correct result.
- STEP=4 and STEP=8 builds: repeat the first three scenarios -> identical results with latency 2 and 1 cycles respectively. Random sweep of 1000 operand/mode pairs matches the a±b reference model for sum, cout and ovf.
